can_stuff_tx: RTL and testbench

Transmit-side CAN-style frame serializer. Accepts payload bytes over a valid/ready handshake and emits a start-of-frame bit, the payload (MSB first), and the CRC remainder onto a single serial line. It inserts stuff bits after runs of identical bits and closes the frame with recessive end-of-frame bits. It produces the bit stream that the team's receive path (`canUnstuff` → `canCRC` → SPI inspection) decodes, and exposes the running CRC for the same SPI readout.

---
 rtl/can_stuff_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_can_stuff_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_stuff_tx.sv
// CAN-style transmit serializer: SOF, MSB-first payload, optional CRC, bit stuffing, EOF.
// Define CAN_STUFF_TX_CRC_EN to compile in the CRC register and CRC phase.
module can_stuff_tx #(
   parameter int CONSEC   = 2,
   parameter int CRC_BITS = 8,
   parameter int CRC_POLY = 150,
   parameter int EOF_BITS = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bit_en,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic                tx,
   output logic                data_bit,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [CRC_BITS-1:0] crc
);
   localparam int RUN_W   = $clog2(CONSEC + 1);
   localparam int CNT_MAX = (CRC_BITS > EOF_BITS) ? CRC_BITS : EOF_BITS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [RUN_W-1:0]    RUN_STUFF = RUN_W'(CONSEC);
   localparam logic [CNT_W-1:0]    EOF_LAST  = CNT_W'(EOF_BITS - 1);
   localparam logic [CRC_BITS-1:0] POLY      = CRC_BITS'(CRC_POLY);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_EOF} state_t;

   state_t           state, state_nx;
   logic [7:0]       buf_data, buf_data_nx, shift, shift_nx;
   logic             buf_last, buf_last_nx, buf_full, buf_full_nx;
   logic             shift_last, shift_last_nx;
   logic [3:0]       bit_cnt, bit_cnt_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [RUN_W-1:0] run, run_nx;
   logic             last_bit, last_bit_nx;
   logic             tx_nx, data_bit_nx, done_nx, err_nx;
   logic             stuff_due, stuff, emit, emit_val;

   function automatic logic [CRC_BITS-1:0] crc_step(input logic [CRC_BITS-1:0] c, input logic d);
      logic fb;
      fb = d ^ c[CRC_BITS-1];
      crc_step = {c[CRC_BITS-2:0], 1'b0} ^ (fb ? POLY : '0);
   endfunction

`ifdef CAN_STUFF_TX_CRC_EN
   localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_BITS - 1);
   logic [CRC_BITS-1:0] crc_q, crc_nx, crc_sh;
   logic                crc_upd;
   assign crc = crc_q;
`else
   assign crc = '0;
`endif

   assign in_ready  = ~buf_full;
   assign busy      = (state != S_IDLE);
   assign stuff_due = (run == RUN_STUFF);

   always_comb begin
      state_nx      = state;
      buf_data_nx   = buf_data;
      buf_last_nx   = buf_last;
      buf_full_nx   = buf_full;
      shift_nx      = shift;
      shift_last_nx = shift_last;
      bit_cnt_nx    = bit_cnt;
      cnt_nx        = cnt;
      run_nx        = run;
      last_bit_nx   = last_bit;
      tx_nx         = tx;
      data_bit_nx   = data_bit;
      done_nx       = 1'b0;
      err_nx        = 1'b0;
      stuff         = 1'b0;
      emit          = 1'b0;
      emit_val      = 1'b0;
`ifdef CAN_STUFF_TX_CRC_EN
      crc_nx        = crc_q;
      crc_sh        = crc_q << cnt;
      crc_upd       = 1'b0;
`endif
      if (in_valid && !buf_full) begin
         buf_data_nx = in_data;
         buf_last_nx = in_last;
         buf_full_nx = 1'b1;
      end
      if (bit_en) begin
         case (state)
            S_IDLE: begin
               tx_nx       = 1'b1;
               data_bit_nx = 1'b0;
               if (buf_full) begin
                  // SOF is a 0 shifted into a cleared CRC, so the remainder stays zero
                  tx_nx         = 1'b0;
                  data_bit_nx   = 1'b1;
                  run_nx        = RUN_W'(1);
                  last_bit_nx   = 1'b0;
                  shift_nx      = buf_data;
                  shift_last_nx = buf_last;
                  buf_full_nx   = 1'b0;
                  bit_cnt_nx    = '0;
`ifdef CAN_STUFF_TX_CRC_EN
                  crc_nx        = '0;
`endif
                  state_nx      = S_DATA;
               end
            end
            S_DATA: begin
               if (stuff_due) begin
                  stuff = 1'b1;
               end else if (bit_cnt == 4'd8) begin
                  if (buf_full) begin
                     emit          = 1'b1;
                     emit_val      = buf_data[7];
                     shift_nx      = {buf_data[6:0], 1'b0};
                     shift_last_nx = buf_last;
                     buf_full_nx   = 1'b0;
                     bit_cnt_nx    = 4'd1;
                  end else begin
                     tx_nx       = 1'b1;
                     data_bit_nx = 1'b0;
                     err_nx      = 1'b1;
                     run_nx      = '0;
                     last_bit_nx = 1'b1;
                     bit_cnt_nx  = '0;
                     state_nx    = S_IDLE;
                  end
               end else begin
                  emit       = 1'b1;
                  emit_val   = shift[7];
                  shift_nx   = {shift[6:0], 1'b0};
                  bit_cnt_nx = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7 && shift_last) begin
                     bit_cnt_nx = '0;
                     cnt_nx     = '0;
`ifdef CAN_STUFF_TX_CRC_EN
                     state_nx   = S_CRC;
`else
                     state_nx   = S_EOF;
`endif
                  end
               end
`ifdef CAN_STUFF_TX_CRC_EN
               crc_upd = emit;
`endif
            end
`ifdef CAN_STUFF_TX_CRC_EN
            S_CRC: begin
               if (stuff_due) begin
                  stuff = 1'b1;
               end else begin
                  emit     = 1'b1;
                  emit_val = crc_sh[CRC_BITS-1];
                  cnt_nx   = cnt + 1'b1;
                  if (cnt == CRC_LAST) begin
                     cnt_nx   = '0;
                     state_nx = S_EOF;
                  end
               end
            end
`endif
            S_EOF: begin
               // a stuff bit still owed from the last coded bit goes out before the EOF ones
               if (stuff_due) begin
                  stuff = 1'b1;
               end else begin
                  tx_nx       = 1'b1;
                  data_bit_nx = 1'b0;
                  run_nx      = '0;
                  cnt_nx      = cnt + 1'b1;
                  if (cnt == EOF_LAST) begin
                     cnt_nx   = '0;
                     done_nx  = 1'b1;
                     state_nx = S_IDLE;
                  end
               end
            end
            default: state_nx = S_IDLE;
         endcase
         if (stuff) begin
            tx_nx       = ~last_bit;
            data_bit_nx = 1'b0;
            run_nx      = RUN_W'(1);
            last_bit_nx = ~last_bit;
         end
         if (emit) begin
            tx_nx       = emit_val;
            data_bit_nx = 1'b1;
            run_nx      = (emit_val == last_bit) ? run + 1'b1 : RUN_W'(1);
            last_bit_nx = emit_val;
         end
`ifdef CAN_STUFF_TX_CRC_EN
         if (crc_upd) crc_nx = crc_step(crc_q, emit_val);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         buf_full <= 1'b0;
         bit_cnt  <= '0;
         cnt      <= '0;
         run      <= '0;
         last_bit <= 1'b1;
         tx       <= 1'b1;
         data_bit <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef CAN_STUFF_TX_CRC_EN
         crc_q    <= '0;
`endif
      end else begin
         state    <= state_nx;
         buf_full <= buf_full_nx;
         bit_cnt  <= bit_cnt_nx;
         cnt      <= cnt_nx;
         run      <= run_nx;
         last_bit <= last_bit_nx;
         tx       <= tx_nx;
         data_bit <= data_bit_nx;
         done     <= done_nx;
         err      <= err_nx;
`ifdef CAN_STUFF_TX_CRC_EN
         crc_q    <= crc_nx;
`endif
      end
   end

   always_ff @(posedge clk) begin
      buf_data   <= buf_data_nx;
      buf_last   <= buf_last_nx;
      shift      <= shift_nx;
      shift_last <= shift_last_nx;
   end
endmodule

// File: tb/tb_can_stuff_tx.sv
// Directed bench for can_stuff_tx; expectations follow the CAN_STUFF_TX_CRC_EN build setting.
module tb_can_stuff_tx;
   localparam int EOF_BITS = 7;
   localparam int CONSEC   = 2;
`ifdef CAN_STUFF_TX_CRC_EN
   localparam bit          CRC_ON    = 1'b1;
   localparam int          HAND_LEN  = 32;
   localparam logic [31:0] HAND_ZERO = 32'b0010010010010_010010010010_1111111;
   localparam int          DB_ONE    = 17;
   localparam int          DB_THREE  = 33;
   localparam logic [7:0]  EXP_80    = 8'h54;
`else
   localparam bit          CRC_ON    = 1'b0;
   localparam int          HAND_LEN  = 20;
   localparam logic [31:0] HAND_ZERO = {12'b0, 20'b0010010010010_1111111};
   localparam int          DB_ONE    = 9;
   localparam int          DB_THREE  = 25;
   localparam logic [7:0]  EXP_80    = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_en = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready, tx, data_bit, busy, done, err;
   logic [7:0] crc;

   can_stuff_tx dut (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .tx(tx), .data_bit(data_bit), .busy(busy),
      .done(done), .err(err), .crc(crc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [7:0] pl [0:7];
   logic       exp_tx [0:127];
   logic       exp_db [0:127];
   int         exp_len;
   logic [7:0] exp_crc;
   logic       cap_tx [0:127];
   logic       cap_db [0:127];
   logic       cap_err [0:127];
   logic [7:0] cap_crc [0:127];
   int         cap_len, done_cnt, err_cnt;
   logic       timeout;

   // Reference line for an nb-byte frame built straight from the framing rules.
   task automatic build_exp(input int nb);
      logic       bits [0:127];
      int         nbits, run;
      logic [7:0] c;
      logic       fb, last, v;
      nbits = 1;
      bits[0] = 1'b0;
      for (int i = 0; i < nb; i++)
         for (int k = 7; k >= 0; k--) begin
            bits[nbits] = pl[i][k];
            nbits++;
         end
      c = 8'h00;
      for (int j = 0; j < nbits; j++) begin
         fb = bits[j] ^ c[7];
         c = {c[6:0], 1'b0} ^ (fb ? 8'h96 : 8'h00);
      end
      exp_crc = CRC_ON ? c : 8'h00;
      if (CRC_ON)
         for (int k = 7; k >= 0; k--) begin
            bits[nbits] = c[k];
            nbits++;
         end
      exp_len = 0;
      last = 1'b0;
      run = 0;
      for (int j = 0; j < nbits; j++) begin
         if (j > 0 && run == CONSEC) begin
            last = ~last;
            run = 1;
            exp_tx[exp_len] = last; exp_db[exp_len] = 1'b0; exp_len++;
         end
         v = bits[j];
         if (j > 0 && v == last) run++;
         else run = 1;
         last = v;
         exp_tx[exp_len] = v; exp_db[exp_len] = 1'b1; exp_len++;
      end
      if (run == CONSEC) begin
         exp_tx[exp_len] = ~last; exp_db[exp_len] = 1'b0; exp_len++;
      end
      for (int e = 0; e < EOF_BITS; e++) begin
         exp_tx[exp_len] = 1'b1; exp_db[exp_len] = 1'b0; exp_len++;
      end
   endtask

   // Feeds nsup bytes (in_last on byte nb-1), strobes bit_en every 'period' clocks and
   // records one sample per bit time from SOF until done/err, or until abort_at samples.
   task automatic run_frame(input int nb, input int nsup, input int period, input int abort_at);
      int   idx, cyc;
      logic xfer, prev_ben, started, finished;
      idx = 0; cyc = 0; xfer = 0; prev_ben = 0; started = 0; finished = 0;
      cap_len = 0; done_cnt = 0; err_cnt = 0;
      while (!finished && cyc < 3000) begin
         @(negedge clk);
         if (xfer) idx++;
         if (done === 1'b1) done_cnt++;
         if (err === 1'b1) err_cnt++;
         if (prev_ben) begin
            if (!started && tx === 1'b0) started = 1;
            if (started && cap_len < 128) begin
               cap_tx[cap_len] = tx; cap_db[cap_len] = data_bit;
               cap_err[cap_len] = err; cap_crc[cap_len] = crc;
               cap_len++;
            end
            if (done === 1'b1 || err === 1'b1) finished = 1;
         end
         if (abort_at > 0 && cap_len >= abort_at) finished = 1;
         if (finished) begin
            bit_en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
         end else begin
            in_valid = (idx < nsup);
            in_data  = (idx < 8) ? pl[idx] : 8'h00;
            in_last  = (idx == nb - 1);
            xfer     = in_valid && in_ready;
            bit_en   = (cyc % period == 0);
            prev_ben = bit_en;
            cyc++;
         end
      end
      timeout = !finished;
      bit_en = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (data_bit !== 1'b0) begin bad++; $display("FAIL reset_data_bit got=%b want=0", data_bit); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (crc !== 8'h00) begin bad++; $display("FAIL reset_crc got=%h want=00", crc); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_zero;
      logic [31:0] hv;
      int nd;
      hv = HAND_ZERO;
      pl[0] = 8'h00;
      run_frame(1, 1, 3, 0);
      total++; if (timeout) begin bad++; $display("FAIL zero_timeout got=timeout want=done"); end
      total++; if (cap_len != HAND_LEN) begin bad++; $display("FAIL zero_len got=%0d want=%0d", cap_len, HAND_LEN); end
      for (int i = 0; i < HAND_LEN; i++) begin
         total++;
         if (cap_tx[i] !== hv[HAND_LEN-1-i]) begin
            bad++; $display("FAIL zero_tx[%0d] got=%b want=%b", i, cap_tx[i], hv[HAND_LEN-1-i]);
         end
      end
      nd = 0;
      for (int i = 0; i < cap_len; i++) if (cap_db[i] === 1'b1) nd++;
      total++; if (nd != DB_ONE) begin bad++; $display("FAIL zero_data_bits got=%0d want=%0d", nd, DB_ONE); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", done_cnt); end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL zero_err_pulses got=%0d want=0", err_cnt); end
      total++; if (crc !== 8'h00) begin bad++; $display("FAIL zero_crc got=%h want=00", crc); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%b want=0", busy); end
   endtask

   task automatic test_crc_80;
      int nd, at;
      logic [7:0] line_crc;
      pl[0] = 8'h80;
      build_exp(1);
      run_frame(1, 1, 1, 0);
      total++; if (timeout) begin bad++; $display("FAIL c80_timeout got=timeout want=done"); end
      total++; if (cap_len != exp_len) begin bad++; $display("FAIL c80_len got=%0d want=%0d", cap_len, exp_len); end
      for (int i = 0; i < exp_len; i++) begin
         total++;
         if (cap_tx[i] !== exp_tx[i] || cap_db[i] !== exp_db[i]) begin
            bad++; $display("FAIL c80_bit[%0d] got=%b/%b want=%b/%b", i, cap_tx[i], cap_db[i], exp_tx[i], exp_db[i]);
         end
      end
      nd = 0; at = -1; line_crc = 8'h00;
      for (int i = 0; i < cap_len; i++)
         if (cap_db[i] === 1'b1) begin
            nd++;
            if (nd == 9) at = i;
            if (nd > 9 && nd <= 17) line_crc = {line_crc[6:0], cap_tx[i]};
         end
      total++;
      if (at < 0) begin bad++; $display("FAIL c80_crc_after_payload got=no_payload want=%h", EXP_80); end
      else if (cap_crc[at] !== EXP_80) begin bad++; $display("FAIL c80_crc_after_payload got=%h want=%h", cap_crc[at], EXP_80); end
`ifdef CAN_STUFF_TX_CRC_EN
      total++; if (line_crc !== 8'b0101_0100) begin bad++; $display("FAIL c80_crc_on_line got=%b want=01010100", line_crc); end
`endif
      total++; if (crc !== EXP_80) begin bad++; $display("FAIL c80_crc_held got=%h want=%h", crc, EXP_80); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL c80_done_pulses got=%0d want=1", done_cnt); end
   endtask

   task automatic test_three_bytes;
      int nd, run, maxrun;
      logic [23:0] payload;
      pl[0] = 8'hA5; pl[1] = 8'hFF; pl[2] = 8'h3C;
      build_exp(3);
      run_frame(3, 3, 1, 0);
      total++; if (timeout) begin bad++; $display("FAIL three_timeout got=timeout want=done"); end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL three_err_pulses got=%0d want=0", err_cnt); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL three_done_pulses got=%0d want=1", done_cnt); end
      nd = 0; payload = '0;
      for (int i = 0; i < cap_len; i++)
         if (cap_db[i] === 1'b1) begin
            nd++;
            if (nd >= 2 && nd <= 25) payload = {payload[22:0], cap_tx[i]};
         end
      total++; if (nd != DB_THREE) begin bad++; $display("FAIL three_data_bits got=%0d want=%0d", nd, DB_THREE); end
      total++; if (payload !== 24'hA5FF3C) begin bad++; $display("FAIL three_payload got=%h want=a5ff3c", payload); end
      run = 0; maxrun = 0;
      for (int i = 0; i < cap_len - EOF_BITS; i++) begin
         if (i > 0 && cap_tx[i] === cap_tx[i-1]) run++;
         else run = 1;
         if (run > maxrun) maxrun = run;
      end
      total++; if (maxrun > CONSEC || maxrun == 0) begin bad++; $display("FAIL three_max_run got=%0d want=1..2", maxrun); end
      total++; if (cap_len != exp_len) begin bad++; $display("FAIL three_len got=%0d want=%0d", cap_len, exp_len); end
      for (int i = 0; i < exp_len; i++) begin
         total++;
         if (cap_tx[i] !== exp_tx[i] || cap_db[i] !== exp_db[i]) begin
            bad++; $display("FAIL three_bit[%0d] got=%b/%b want=%b/%b", i, cap_tx[i], cap_db[i], exp_tx[i], exp_db[i]);
         end
      end
      total++; if (crc !== exp_crc) begin bad++; $display("FAIL three_crc got=%h want=%h", crc, exp_crc); end
   endtask

   task automatic test_underrun;
      logic [31:0] hv;
      int extra_done, zero_bits;
      hv = HAND_ZERO;
      pl[0] = 8'h00;
      run_frame(2, 1, 1, 0);
      total++; if (timeout) begin bad++; $display("FAIL under_timeout got=timeout want=err"); end
      total++; if (err_cnt != 1) begin bad++; $display("FAIL under_err_pulses got=%0d want=1", err_cnt); end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL under_done_pulses got=%0d want=0", done_cnt); end
      total++; if (cap_len != 14) begin bad++; $display("FAIL under_len got=%0d want=14", cap_len); end
      for (int i = 0; i < 13; i++) begin
         total++;
         if (cap_tx[i] !== hv[HAND_LEN-1-i]) begin
            bad++; $display("FAIL under_tx[%0d] got=%b want=%b", i, cap_tx[i], hv[HAND_LEN-1-i]);
         end
      end
      total++; if (cap_tx[13] !== 1'b1 || cap_err[13] !== 1'b1) begin
         bad++; $display("FAIL under_abort_bit got=tx%b/err%b want=tx1/err1", cap_tx[13], cap_err[13]);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL under_busy got=%b want=0", busy); end
      extra_done = 0; zero_bits = 0;
      bit_en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
         if (tx !== 1'b1) zero_bits++;
      end
      bit_en = 1'b0;
      total++; if (extra_done != 0) begin bad++; $display("FAIL under_late_done got=%0d want=0", extra_done); end
      total++; if (zero_bits != 0) begin bad++; $display("FAIL under_idle_line got=%0d_non_recessive want=0", zero_bits); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] hv;
      hv = HAND_ZERO;
      pl[0] = 8'h80;
      run_frame(1, 1, 1, 4);
      total++; if (tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre_reset got=tx%b/busy%b want=tx0/busy1", tx, busy); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx got=%b want=1", tx); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
      total++; if (crc !== 8'h00) begin bad++; $display("FAIL mid_crc got=%h want=00", crc); end
      total++; if (busy !== 1'b0 || data_bit !== 1'b0) begin bad++; $display("FAIL mid_busy got=busy%b/db%b want=0/0", busy, data_bit); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pl[0] = 8'h00;
      run_frame(1, 1, 2, 0);
      total++; if (cap_len != HAND_LEN || done_cnt != 1) begin
         bad++; $display("FAIL mid_refrm_len got=%0d/done%0d want=%0d/done1", cap_len, done_cnt, HAND_LEN);
      end
      for (int i = 0; i < HAND_LEN; i++) begin
         total++;
         if (cap_tx[i] !== hv[HAND_LEN-1-i]) begin
            bad++; $display("FAIL mid_refrm_tx[%0d] got=%b want=%b", i, cap_tx[i], hv[HAND_LEN-1-i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_zero;
      test_crc_80;
      test_three_bytes;
      test_underrun;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
